// File: rtl/fphub_pkg.sv
// Shared types for the FPHUB adder scheduler: FSM state encoding and the
// in-flight tag carried alongside each adder operation.
package fphub_pkg;

    localparam int SCHED_N_REQ = 4;
    localparam int ID_W        = $clog2(SCHED_N_REQ);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } sched_state_t;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/fphub_adder_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr.
// The pointer itself lives in the scheduler.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);

    // Walk from farthest to nearest so the position closest to ptr wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        if (en) begin
            for (int k = N - 1; k >= 0; k--) begin
                if (req[(int'(ptr) + k) % N]) begin
                    gnt                        = '0;
                    gnt[(int'(ptr) + k) % N]   = 1'b1;
                    idx                        = IW'((int'(ptr) + k) % N);
                end
            end
        end
    end

endmodule

// File: rtl/fphub_adder_scheduler.sv
// Round-robin scheduler sharing one FPHUB adder among N_REQ requesters.
// Optional FPHUB_SCHED_SUB_EN adds req_sub to flip the sign of Y (X - Y).
//
// state  | meaning
// RUN    | granting requests round-robin
// DRAIN  | issue stopped, waiting for in-flight tags to leave
// HALTED | pipeline empty, issue stopped until halt_req drops
module fphub_adder_scheduler
    import fphub_pkg::*;
#(
    parameter int E       = 8,
    parameter int M       = 23,
    parameter int N_REQ   = 4,
    parameter int ADD_LAT = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_REQ-1:0]                req_valid,
`ifdef FPHUB_SCHED_SUB_EN
    input  logic [N_REQ-1:0]                req_sub,
`endif
    output logic [N_REQ-1:0]                req_ready,
    input  logic [N_REQ-1:0][E+M:0]         req_x,
    input  logic [N_REQ-1:0][E+M:0]         req_y,
    output logic [E+M:0]                    add_x,
    output logic [E+M:0]                    add_y,
    input  logic [E+M:0]                    add_z,
    output logic                            resp_valid,
    output logic [$clog2(N_REQ)-1:0]        resp_id,
    output logic [E+M:0]                    resp_z,
    input  logic                            halt_req,
    output logic                            halted,
    output logic                            busy
);

    localparam int W   = E + M + 1;
    localparam int IW  = $clog2(N_REQ);
    localparam int NST = ADD_LAT + 1;

    sched_state_t    state, state_nxt;
    logic [IW-1:0]   ptr;
    logic [N_REQ-1:0] gnt;
    logic [IW-1:0]   gidx;
    logic            arb_en;
    logic            issue;
    logic [W-1:0]    y_sel;
    tag_t            tags [NST];

    // Reset also blocks grants so req_ready reads zero while rst is held.
    assign arb_en = (state == RUN) && !halt_req && !rst;

    rr_arbiter #(
        .N  (N_REQ),
        .IW (IW)
    ) u_arb (
        .req (req_valid),
        .ptr (ptr),
        .en  (arb_en),
        .gnt (gnt),
        .idx (gidx)
    );

    assign req_ready = gnt;
    assign issue     = |gnt;
    assign halted    = (state == HALTED);

`ifdef FPHUB_SCHED_SUB_EN
    assign y_sel = req_sub[gidx] ? {~req_y[gidx][W-1], req_y[gidx][W-2:0]}
                                 : req_y[gidx];
`else
    assign y_sel = req_y[gidx];
`endif

    always_comb begin
        busy = 1'b0;
        for (int s = 0; s < NST; s++) begin
            busy = busy | tags[s].valid;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            RUN:     if (halt_req)  state_nxt = DRAIN;
            DRAIN:   if (!busy)     state_nxt = HALTED;
            HALTED:  if (!halt_req) state_nxt = RUN;
            default:                state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            if (issue) begin
                ptr <= (gidx == IW'(N_REQ - 1)) ? '0 : gidx + 1'b1;
            end
        end
    end

    // Operands hold their last issued value while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            add_x <= '0;
            add_y <= '0;
        end else if (issue) begin
            add_x <= req_x[gidx];
            add_y <= y_sel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < NST; s++) begin
                tags[s] <= '0;
            end
        end else begin
            tags[0] <= '{valid: issue, id: gidx};
            for (int s = 1; s < NST; s++) begin
                tags[s] <= tags[s-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid <= 1'b0;
            resp_id    <= '0;
            resp_z     <= '0;
        end else begin
            resp_valid <= tags[NST-1].valid;
            resp_id    <= tags[NST-1].id;
            resp_z     <= add_z;
        end
    end

endmodule
